addr8s_tmr_sched: RTL and testbench
===================================

Name: addr8s_tmr_sched

Overview:
- Round-robin scheduler that shares one external 8-bit signed adder (9-bit sum out) between N_REQ requesters.
- Applies temporal redundancy: each accepted operation is evaluated twice, first A+B then B+A with operands swapped, so that different gate paths are exercised. The two sums are compared.
- On mismatch the operation retries up to MAX_RETRY times, then returns the result with an error flag.
- Sits between requester clients and the combinational adder instance; the adder itself is unchanged.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 2, extra evaluation pairs allowed after the first mismatch (0..7).
- IDW, $clog2(N_REQ), requester id width (derived).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester operation request.
- req_a  input  8*N_REQ  signed operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*N_REQ  signed operand B, packed the same way.
- req_ready  output  N_REQ  one-hot grant; a handshake completes where valid&ready.
- add_a  output  8  operand A to the shared adder.
- add_b  output  8  operand B to the shared adder.
- add_sum  input  9  combinational sum from the shared adder (two's complement).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_sum  output  9  signed sum.
- rsp_id  output  IDW  index of the granted requester.
- rsp_err  output  1  retries exhausted without the two sums agreeing.
- err_count  output  8  saturating count of mismatching compares.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, retry_cnt=0.
  - Internal s1 and s2 are cleared.
  - All outputs are 0, including err_count.
  - Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, RUN1, RUN2, CHECK, RESP.
- IDLE:
  - Winner g is the first asserted req_valid searching from rr_ptr upward, wrapping modulo N_REQ.
  - req_ready is combinational, one-hot at g, and is asserted only in IDLE.
  - On the handshake: latch opA, opB and id=g; set rr_ptr<=(g+1) mod N_REQ; set retry_cnt<=0; go to RUN1.
  - With no request, state remains IDLE.
- RUN1: add_a=opA, add_b=opB; s1<=add_sum; go to RUN2.
- RUN2: add_a=opB, add_b=opA; s2<=add_sum; go to CHECK.
- add_a and add_b are 0 in every state other than RUN1 and RUN2.
- CHECK:
  - If s1==s2: go to RESP with rsp_err=0.
  - Else err_count increments, saturating at 255. Then:
    - If retry_cnt<MAX_RETRY: retry_cnt++ and go back to RUN1.
    - Otherwise go to RESP with rsp_err=1 and rsp_sum=s1 (the first evaluation).
- RESP:
  - rsp_valid=1; rsp_sum, rsp_id and rsp_err are registered and held stable until rsp_ready.
  - On the handshake go to IDLE and drop rsp_valid the next cycle.
  - No grant is issued while in RESP.
- Latency:
  - Handshake in cycle T gives rsp_valid at T+4 with no retries.
  - Each retry adds 3 cycles.
  - Back-to-back throughput is one operation per 5 cycles, because the next grant comes in the IDLE cycle after the response handshake.
- Arithmetic: the scheduler never adds; it only compares the two 9-bit values for equality.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait.
- The module never drops req_valid on a requester's behalf.

Test Plan:
- Single request, req 2, a=0x7F, b=0x01, rsp_ready=1:
  - req_ready=4'b0100 in the same cycle.
  - rsp_valid at T+4 with rsp_sum=9'h080, rsp_id=2, rsp_err=0.
- Negative operands, a=0x80, b=0x80, then a=0xFF, b=0x01 → rsp_sum=9'h100, then 9'h000.
- All four req_valid held high for 20 ops, rsp_ready=1 → grant order 0,1,2,3,0,1,… with responses spaced 5 cycles apart.
- Adder model corrupts bit 0 only on the first RUN2 evaluation:
  - One retry.
  - rsp_valid at T+7 with the correct sum, rsp_err=0, err_count=1.
- Persistent fault (RUN2 sum always XOR 1), MAX_RETRY=2:
  - rsp_valid at T+10 with rsp_err=1 and rsp_sum=the RUN1 value.
  - err_count=3.
- Backpressure and reset:
  - Hold rsp_ready=0 for 6 cycles in RESP → outputs stable, req_ready=0 throughout.
  - Pulse rst_n=0 during RUN2 → all outputs 0 immediately; the next request is served from rr_ptr=0.

Source files
------------

// File: rtl/addr8s_tmr_sched.sv
// Round-robin scheduler sharing one external 8-bit signed adder between N_REQ requesters.
// Each operation is evaluated as A+B then B+A; a disagreement is retried, then reported with rsp_err.
module addr8s_tmr_sched #(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 2,
  parameter int IDW       = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         add_a,
  output logic [7:0]         add_b,
  input  logic [8:0]         add_sum,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [8:0]         rsp_sum,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_err,
  output logic [7:0]         err_count,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, RUN1, RUN2, CHECK, RESP} state_t;

  localparam logic [2:0]   MAX_R = 3'(MAX_RETRY);
  localparam logic [IDW:0] N_W   = (IDW+1)'(N_REQ);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, g, id, ptr_nxt;
  logic [IDW:0]   cand, ptr_inc;
  logic           found, hs, mismatch, finish;
  logic [7:0]     op_a, op_b;
  logic [8:0]     s1, s2;
  logic [2:0]     retry_cnt;

  // First asserted request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    g     = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        g     = cand[IDW-1:0];
      end
    end
  end

  assign ptr_inc  = {1'b0, g} + (IDW+1)'(1);
  assign ptr_nxt  = (ptr_inc == N_W) ? '0 : ptr_inc[IDW-1:0];
  // Grants are suppressed while reset is held so every output reads 0 during reset.
  assign hs       = (state == IDLE) && found && rst_n;
  assign mismatch = (s1 != s2);
  assign finish   = !mismatch || (retry_cnt >= MAX_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    case (state)
      IDLE: begin
        if (hs) begin
          req_ready[g] = 1'b1;
          state_nxt    = RUN1;
        end
      end
      RUN1: begin
        add_a     = op_a;
        add_b     = op_b;
        state_nxt = RUN2;
      end
      RUN2: begin
        add_a     = op_b;
        add_b     = op_a;
        state_nxt = CHECK;
      end
      CHECK:   state_nxt = finish ? RESP : RUN1;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      retry_cnt <= '0;
      op_a      <= '0;
      op_b      <= '0;
      id        <= '0;
      s1        <= '0;
      s2        <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            op_a      <= req_a[8*g +: 8];
            op_b      <= req_b[8*g +: 8];
            id        <= g;
            rr_ptr    <= ptr_nxt;
            retry_cnt <= '0;
          end
        end
        RUN1: s1 <= add_sum;
        RUN2: s2 <= add_sum;
        CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (retry_cnt < MAX_R)  retry_cnt <= retry_cnt + 3'd1;
          end
          // On exhaustion the first evaluation is the reported result.
          if (finish) begin
            rsp_sum <= s1;
            rsp_id  <= id;
            rsp_err <= mismatch;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr8s_tmr_sched.sv
// Bench for addr8s_tmr_sched: vector table, directed retry/backpressure/reset sequences, random traffic vs a queue-level model.
module tb_addr8s_tmr_sched;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     add_a, add_b;
  logic [8:0]     add_sum;
  logic           rsp_valid, rsp_ready = 1'b0;
  logic [8:0]     rsp_sum;
  logic [1:0]     rsp_id;
  logic           rsp_err;
  logic [7:0]     err_count;
  logic           busy;

  int n_chk = 0, n_pass = 0;
  int fault_mode = 0;
  int since = 100;
  logic corrupt;

  addr8s_tmr_sched #(.N_REQ(N), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder model: cycles since the last grant locate the swapped evaluation (1, 4, 7 after the grant edge).
  always @(posedge clk) begin
    if (|(req_valid & req_ready)) since <= 0;
    else if (since < 1000)        since <= since + 1;
  end
  always_comb corrupt = (fault_mode == 1 && since == 1) ||
                        (fault_mode == 2 && since % 3 == 1 && since < 9);
  assign add_sum = ({add_a[7], add_a} + {add_b[7], add_b}) ^ {8'b0, corrupt};

  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return s[8:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  // Called right after the grant cycle was sampled; drops requests and waits for the response.
  task automatic wait_rsp(input int lat, input logic [8:0] sum, input int id, input logic err);
    int k;
    bit got;
    k = 0;
    got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      req_valid = '0;
      k++;
      #1;
      if (rsp_valid) got = 1;
    end
    chk("latency", k, lat);
    chk("rsp_sum", 32'(rsp_sum), 32'(sum));
    chk("rsp_id", 32'(rsp_id), id);
    chk("rsp_err", 32'(rsp_err), 32'(err));
    @(negedge clk);
    #1;
    chk("rsp_drop", 32'(rsp_valid), 0);
  endtask

  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input logic [8:0] sum, input logic err);
    @(negedge clk);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    rsp_ready = 1'b1;
    #1;
    chk("grant", 32'(req_ready), 1 << id);
    wait_rsp(lat, sum, id, err);
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] ra[N], rb[N];
  logic [7:0] pa[N], pb[N];
  bit pend[N];

  initial begin
    vecs[0] = '{2, 8'h7F, 8'h01, 9'h080};
    vecs[1] = '{2, 8'h80, 8'h80, 9'h100};
    vecs[2] = '{2, 8'hFF, 8'h01, 9'h000};
    vecs[3] = '{0, 8'h7F, 8'h7F, 9'h0FE};
    vecs[4] = '{3, 8'h80, 8'h7F, 9'h1FF};
    vecs[5] = '{1, 8'h00, 8'h00, 9'h000};

    // Reset state, with requests pending.
    req_valid = 4'hF;
    #12;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_add", 32'({add_a, add_b}), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_rsp", 32'({rsp_sum, rsp_id, rsp_err}), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters held high: grants rotate 0,1,2,3 and responses are 5 cycles apart.
    begin
      int nresp, ngr, cyc, last;
      nresp = 0; ngr = 0; cyc = 0; last = 0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ra[i] = 8'(i * 37 + 5);
        rb[i] = 8'(8'hC0 - i * 9);
        req_a[8*i +: 8] = ra[i];
        req_b[8*i +: 8] = rb[i];
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #1;
      while (nresp < 20 && cyc < 300) begin
        if (req_ready != '0) begin
          chk("rr_grant", 32'(req_ready), 1 << (ngr % N));
          ngr++;
        end
        if (rsp_valid) begin
          chk("rr_id", 32'(rsp_id), nresp % N);
          chk("rr_sum", 32'(rsp_sum), 32'(ref_sum(ra[nresp % N], rb[nresp % N])));
          if (nresp > 0) chk("rr_gap", cyc - last, 5);
          last = cyc;
          nresp++;
          if (nresp == 20) req_valid = '0;
        end
        @(negedge clk);
        cyc++;
        #1;
      end
      chk("rr_count", nresp, 20);
    end

    foreach (vecs[i]) run_op(vecs[i].id, vecs[i].a, vecs[i].b, 4, vecs[i].sum, 1'b0);

    // Transient fault on the first swapped evaluation: one retry, correct result.
    fault_mode = 1;
    run_op(1, 8'h12, 8'h34, 7, 9'h046, 1'b0);
    chk("errcnt_1", 32'(err_count), 1);
    // Persistent fault: retries exhausted, first evaluation reported.
    fault_mode = 2;
    run_op(0, 8'h10, 8'h20, 10, 9'h030, 1'b1);
    chk("errcnt_4", 32'(err_count), 4);
    for (int i = 0; i < 84; i++) run_op(0, 8'h01, 8'h02, 10, 9'h003, 1'b1);
    chk("errcnt_sat", 32'(err_count), 255);
    fault_mode = 0;

    // Backpressure: response held stable, no grant to a waiting requester.
    @(negedge clk);
    req_valid = 4'b1000;
    req_a[31:24] = 8'h05;
    req_b[31:24] = 8'h06;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h8);
    begin
      int k;
      k = 0;
      while (!rsp_valid && k < 40) begin
        @(negedge clk);
        req_valid = 4'b0010;
        k++;
        #1;
      end
      chk("bp_latency", k, 4);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_hold", 32'({rsp_sum, rsp_id, rsp_err}), 32'({9'h00B, 2'd3, 1'b0}));
      chk("bp_noready", 32'(req_ready), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    chk("bp_release", 32'(rsp_valid), 1);
    @(negedge clk);
    #1;
    chk("bp_idle", 32'({rsp_valid, busy}), 0);

    // Reset during RUN2 abandons the operation and restarts the pointer at 0.
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[23:16] = 8'h11;
    req_b[23:16] = 8'h22;
    #1;
    chk("rs_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rs_run1", 32'({add_a, add_b}), 32'h1122);
    @(negedge clk);
    #1;
    chk("rs_run2", 32'({add_a, add_b}), 32'h2211);
    rst_n = 1'b0;
    #1;
    chk("rs_outs", 32'({req_ready, add_a, add_b, rsp_valid, busy}), 0);
    chk("rs_rsp", 32'({rsp_sum, rsp_id, rsp_err}), 0);
    chk("rs_errcnt", 32'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("rs_norsp", 32'({rsp_valid, busy}), 0);
    end
    @(negedge clk);
    req_valid = 4'b1010;
    req_a[15:8] = 8'hF0; req_b[15:8] = 8'hF0;
    req_a[31:24] = 8'h01; req_b[31:24] = 8'h01;
    #1;
    chk("rs_ptr0", 32'(req_ready), 32'h2);
    wait_rsp(4, 9'h1E0, 1, 1'b0);

    // Random traffic against a queue-level model; last grant went to 1.
    begin
      int rr, age, w, e_id;
      bit mbusy;
      logic [8:0] e_sum;
      rr = 2; age = 0; mbusy = 0; e_id = 0; e_sum = '0;
      for (int i = 0; i < N; i++) pend[i] = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(0, 3) == 0) begin
            pend[i] = 1;
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
          end
          req_valid[i] = pend[i];
          req_a[8*i +: 8] = pa[i];
          req_b[8*i +: 8] = pb[i];
        end
        rsp_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (!mbusy) begin
          w = -1;
          for (int k = 0; k < N; k++) if (w < 0 && pend[(rr + k) % N]) w = (rr + k) % N;
          chk("rnd_grant", 32'(req_ready), (w < 0) ? 0 : (1 << w));
          chk("rnd_idle", 32'(rsp_valid), 0);
          if (w >= 0) begin
            mbusy = 1; age = 0; e_id = w;
            e_sum = ref_sum(pa[w], pb[w]);
            rr = (w + 1) % N;
            pend[w] = 0;
          end
        end else begin
          age++;
          chk("rnd_nogrant", 32'(req_ready), 0);
          chk("rnd_valid", 32'(rsp_valid), (age >= 4) ? 1 : 0);
          if (age >= 4) begin
            chk("rnd_sum", 32'(rsp_sum), 32'(e_sum));
            chk("rnd_id", 32'(rsp_id), e_id);
            chk("rnd_err", 32'(rsp_err), 0);
            if (rsp_ready) mbusy = 0;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
